// File: rtl/pipelined_carry_select_adder_pkg.sv
// Shared ALU definitions for the pipelined carry-select adder/subtractor:
// default width, mode encoding and the width-independent stage-1 flag bundle.
package pipelined_carry_select_adder_pkg;

    localparam int ADDER_WIDTH = 32;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_mode_e;

    // Single-bit part of the stage-1 register bundle; the sum fields are sized
    // by the adder instance and wrap this struct.
    typedef struct packed {
        logic lo_cout;
        logic hi_cout0;
        logic hi_cout1;
        logic a_msb;
        logic beff_msb;
    } s1_flags_t;

    // Subtraction computes A + ~B + ~borrow, so the borrow input is inverted.
    function automatic logic eff_cin(input alu_mode_e mode, input logic carry_in);
        return (mode == ALU_SUB) ? ~carry_in : carry_in;
    endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_csa_segment.sv
// One carry-select segment: a SEG-bit ripple adder evaluated for both
// possible carry-in values so the caller only has to pick a result.
module csa_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    output logic [SEG-1:0] sum0,
    output logic           cout0,
    output logic [SEG-1:0] sum1,
    output logic           cout1
);

    logic c0;
    logic c1;

    // NOTE: blocking assignments are correct here; the carry variables are
    // combinational temporaries that must ripple within one evaluation.
    always_comb begin
        sum0 = '0;
        sum1 = '0;
        c0   = 1'b0;
        c1   = 1'b1;
        for (int i = 0; i < SEG; i++) begin
            sum0[i] = a[i] ^ b[i] ^ c0;
            c0      = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
            sum1[i] = a[i] ^ b[i] ^ c1;
            c1      = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
        end
        cout0 = c0;
        cout1 = c1;
    end

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshakes.
// Stage 1 resolves the low half and both upper-half candidates; stage 2 selects.
module pipelined_carry_select_adder
    import pipelined_carry_select_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int SEG   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int HALF = WIDTH / 2;
    localparam int NLO  = HALF / SEG;
    localparam int NSEG = 2 * NLO;

    if ((WIDTH % 2) != 0 || WIDTH < 4 || SEG < 1 || (HALF % SEG) != 0) begin : g_param_check
        $fatal(1, "pipelined_carry_select_adder: WIDTH must be even and >= 4, SEG must divide WIDTH/2");
    end

    typedef struct packed {
        logic [HALF-1:0] lo_sum;
        logic [HALF-1:0] hi_sum0;
        logic [HALF-1:0] hi_sum1;
        s1_flags_t       flags;
    } s1_bundle_t;

    alu_mode_e        mode;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign mode = alu_mode_e'(sub);

    always_comb begin
        b_eff   = (mode == ALU_SUB) ? ~in_B : in_B;
        cin_eff = eff_cin(mode, carry_in);
    end

    logic [NSEG-1:0][SEG-1:0] seg_sum0;
    logic [NSEG-1:0][SEG-1:0] seg_sum1;
    logic [NSEG-1:0]          seg_cout0;
    logic [NSEG-1:0]          seg_cout1;

    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        csa_segment #(
            .SEG (SEG)
        ) u_seg (
            .a     (in_A[i*SEG +: SEG]),
            .b     (b_eff[i*SEG +: SEG]),
            .sum0  (seg_sum0[i]),
            .cout0 (seg_cout0[i]),
            .sum1  (seg_sum1[i]),
            .cout1 (seg_cout1[i])
        );
    end

    // Low half chains on the real carry; the upper half is chained twice,
    // once per assumed carry into its first segment.
    logic [HALF-1:0] lo_sum;
    logic [HALF-1:0] hi_sum0;
    logic [HALF-1:0] hi_sum1;
    logic            c_lo;
    logic            c_h0;
    logic            c_h1;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which is what would otherwise infer a latch.
    always_comb begin
        lo_sum  = '0;
        hi_sum0 = '0;
        hi_sum1 = '0;
        c_lo    = cin_eff;
        c_h0    = 1'b0;
        c_h1    = 1'b1;
        for (int i = 0; i < NLO; i++) begin
            lo_sum[i*SEG +: SEG]  = c_lo ? seg_sum1[i] : seg_sum0[i];
            c_lo                  = c_lo ? seg_cout1[i] : seg_cout0[i];
            hi_sum0[i*SEG +: SEG] = c_h0 ? seg_sum1[NLO+i] : seg_sum0[NLO+i];
            c_h0                  = c_h0 ? seg_cout1[NLO+i] : seg_cout0[NLO+i];
            hi_sum1[i*SEG +: SEG] = c_h1 ? seg_sum1[NLO+i] : seg_sum0[NLO+i];
            c_h1                  = c_h1 ? seg_cout1[NLO+i] : seg_cout0[NLO+i];
        end
    end

    logic       s1_valid_d, s1_valid_q;
    s1_bundle_t s1_d, s1_q;
    logic       s2_free;
    logic       accept;
    logic       advance;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_d, out_q;
    logic             carry_out_d, carry_out_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;

    always_comb begin
        s2_free  = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_free;
        accept   = in_valid && in_ready;
        advance  = s1_valid_q && s2_free;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (accept) begin
            s1_valid_d             = 1'b1;
            s1_d.lo_sum            = lo_sum;
            s1_d.hi_sum0           = hi_sum0;
            s1_d.hi_sum1           = hi_sum1;
            s1_d.flags.lo_cout     = c_lo;
            s1_d.flags.hi_cout0    = c_h0;
            s1_d.flags.hi_cout1    = c_h1;
            s1_d.flags.a_msb       = in_A[WIDTH-1];
            s1_d.flags.beff_msb    = b_eff[WIDTH-1];
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2 loads only on advance, so a stalled result and its flags hold.
    always_comb begin
        out_valid_d = advance || (out_valid_q && !out_ready);
        out_d       = out_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        if (advance) begin
            out_d       = {s1_q.flags.lo_cout ? s1_q.hi_sum1 : s1_q.hi_sum0, s1_q.lo_sum};
            carry_out_d = s1_q.flags.lo_cout ? s1_q.flags.hi_cout1 : s1_q.flags.hi_cout0;
            overflow_d  = (s1_q.flags.a_msb == s1_q.flags.beff_msb) &&
                          (out_d[WIDTH-1] != s1_q.flags.a_msb);
            zero_d      = ~|out_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. The data
    // registers are reset as well so every output reads 0 straight after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: doc/pipelined_carry_select_adder.md
Name: pipelined_carry_select_adder

Overview:
Parametrised, two-stage pipelined carry-select adder/subtractor for the ALU datapath. It has valid/ready handshakes on input and output, a runtime add/subtract mode, and carry, signed-overflow and zero flags. Stage 1 computes the low half and both speculative upper-half results. Stage 2 selects the upper half and derives the flags. It replaces the combinational adder where the timing path needs a register cut.

Parameters:
WIDTH, 32, operand/result width; even, >= 4
SEG, 4, carry-select segment width; must divide WIDTH/2

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts beat this cycle
in_A  input  WIDTH  operand A
in_B  input  WIDTH  operand B
carry_in  input  1  add: carry in; sub: borrow in
sub  input  1  0 = A+B+cin, 1 = A-B-borrow
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out  output  WIDTH  sum/difference
carry_out  output  1  carry out of MSB (sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow
zero  output  1  out == 0

Behaviour:
- One clock: clock. Reset is synchronous, active-high: reset.
- Effective operands:
  - Add: Beff = in_B, cin = carry_in.
  - Sub: Beff = ~in_B, cin = ~carry_in.
  - Arithmetic is modulo 2^WIDTH; carry_out is bit WIDTH of A + Beff + cin.
- Stage 1 (registered on accept):
  - Low half: lo_sum[WIDTH/2-1:0] and lo_cout, built as a chain of SEG-wide carry-select segments.
  - High half: hi_sum0/hi_cout0 assuming carry 0 into the upper half; hi_sum1/hi_cout1 assuming carry 1.
  - Also register A[WIDTH-1] and Beff[WIDTH-1].
- Stage 2 (registered on advance):
  - out = {lo_cout ? hi_sum1 : hi_sum0, lo_sum}; carry_out selected the same way.
  - overflow = (A_msb == Beff_msb) && (out[WIDTH-1] != A_msb).
  - zero = ~|out.
- Latency: 2 cycles from accepted beat to out_valid with no stall. Throughput: 1 beat/cycle.
- Handshake:
  - Accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free (combinational; no dependency on in_valid).
  - Stage 1 advances to stage 2 when s1_valid && s2_free.
- Stall:
  - out_valid && !out_ready holds out and all flags stable.
  - Stage 1 holds while stage 2 is blocked.
  - in_ready falls only when both stages are full and downstream is stalled.
- Simultaneous events:
  - Accept and advance in the same cycle: stage 1 loads the new beat while its old beat moves to stage 2.
  - Output transfer with no advance: out_valid clears next cycle.
- Reset (any cycle, including mid-flight):
  - s1_valid = 0, out_valid = 0; in-flight beats are discarded.
  - out = 0, carry_out = 0, overflow = 0, zero = 0, so zero is 0 while invalid.
  - in_ready = 1 in the cycle after reset deasserts and is combinationally 1 while stage 1 is empty.
- Data registers update only on their load enable; no X propagation from idle inputs.
- Elaboration check: WIDTH/2 % SEG != 0 is a fatal error.

Decomposition:
- Shared ALU package:
  - Default ADDER_WIDTH = 32.
  - Mode encodings ALU_ADD = 1'b0, ALU_SUB = 1'b1.
  - Struct/typedef for the stage-1 register bundle (lo_sum, lo_cout, hi_sum0/1, hi_cout0/1, A_msb, Beff_msb).
- One sub-module, csa_segment:
  - SEG-bit ripple adder producing sum and cout for both carry-in 0 and 1.
  - Generated WIDTH/SEG times; low-half instances are chained by mux select on the incoming carry.

Test Plan:
1. WIDTH=32, add 0x0000FFFF + 0x00000001, cin=0 -> out=0x00010000, carry_out=0, overflow=0, zero=0, out_valid exactly 2 cycles after accept.
2. Add 0x7FFFFFFF + 0x00000001 -> out=0x80000000, overflow=1, carry_out=0. Add 0xFFFFFFFF + 0x00000001 -> out=0, carry_out=1, zero=1, overflow=0.
3. Sub 5 - 7, borrow 0 -> out=0xFFFFFFFE, carry_out=0. Sub 7 - 5, borrow 1 -> out=0x00000001, carry_out=1. Sub 0x80000000 - 1 -> overflow=1.
4. Back-to-back 8 beats with out_ready=1 -> 8 results in consecutive cycles, in order. Then out_ready=0 for 3 cycles -> out stable, in_ready=0 after stage 1 fills, no beat lost or duplicated.
5. Assert reset with both stages full -> next cycle out_valid=0, all outputs 0. First post-reset beat 3+4 -> out=7 two cycles after accept.
6. Randomised 10k beats, WIDTH in {8,32,64} and SEG in {2,4} -> every result and flag matches a behavioural (WIDTH+1)-bit reference model.
